// File: rtl/trunk_unit_pipe.sv
// trunk_unit_pipe: registered load truncation/extension with valid/ready and optional two-beat misaligned assembly
module trunk_unit_pipe #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 12,
  parameter int SPLIT_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        opcode,
  input  logic [DATA_W-1:0] entrada,
  input  logic [ADDR_W-1:0] direccion,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] salida,
  output logic              err
);
  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  localparam int SW = OW + 2;
  localparam int BW = $clog2(DATA_W);
  typedef enum logic {IDLE, WAIT_HI} st_t;
  st_t st, st_n;
  logic [DATA_W-1:0] hold_q, raw, res;
  logic [2:0] op_q, cop;
  logic [OW-1:0] off_q, off;
  logic [SW-1:0] sz;
  logic [OW+3:0] shl;
  logic ill, mis, split, bad, acc, unused;
  function automatic logic [DATA_W-1:0] ext(input logic [DATA_W-1:0] v, input logic [2:0] o);
    logic [DATA_W-1:0] r;
    int nbits;
    logic s;
    nbits = 8 << o[1:0];
    if (nbits > DATA_W) nbits = DATA_W;
    s = !o[2] && v[BW'(nbits - 1)];
    for (int i = 0; i < DATA_W; i++) r[i] = (i < nbits) ? v[i] : s;
    return r;
  endfunction
  assign in_ready = !out_valid || out_ready;
  assign acc = in_valid && in_ready;
  assign off = direccion[OW-1:0];
  assign unused = ^direccion;
  always_comb begin
    cop   = (st == WAIT_HI) ? op_q : opcode;
    sz    = SW'(1) << cop[1:0];
    ill   = (st == IDLE) && (opcode == 3'b111 || (DATA_W == 32 && (opcode == 3'b011 || opcode == 3'b110)));
    mis   = (st == IDLE) && !ill && (SW'(off) + sz > SW'(NB));
    split = mis && (SPLIT_EN != 0);
    bad   = ill || (mis && SPLIT_EN == 0);
    shl   = ((OW+4)'(NB) - (OW+4)'(off_q)) << 3;
    // second beat fills the bytes above the n latched low bytes
    raw   = (st == WAIT_HI) ? (hold_q | (entrada << shl)) : (entrada >> {off, 3'b000});
    res   = bad ? '0 : ext(raw, cop);
    st_n  = acc ? (split ? WAIT_HI : IDLE) : st;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      hold_q    <= '0;
      op_q      <= '0;
      off_q     <= '0;
      out_valid <= 1'b0;
      salida    <= '0;
      err       <= 1'b0;
    end else begin
      st <= st_n;
      if (acc && split) begin
        hold_q <= raw;
        op_q   <= opcode;
        off_q  <= off;
      end
      if (acc && !split) begin
        out_valid <= 1'b1;
        salida    <= res;
        err       <= bad;
      end else if (out_ready) out_valid <= 1'b0;
    end
  end
endmodule
